mac_stream: RTL
===============

// Module: mac_stream
// PURPOSE
//  Pipelined, parameterised multiply-accumulate engine for streamed dot products.
//  Accepts one operand pair per cycle (valid/ready), accumulates products until a
//  term tagged in_last, then emits the vector result with overflow status and term
//  count. Successor to the fixed 32x32 MAC; adds handshakes, signed mode, saturation.
// PARAMETERS
//  DATA_W     32   operand width (bits), >= 2
//  ACC_W      72   accumulator/result width, >= 2*DATA_W
//  SIGNED     0    1 = two's-complement operands/accumulator, 0 = unsigned
//  SATURATE   0    1 = clamp accumulator on overflow, 0 = wrap modulo 2^ACC_W
//  CNT_W      16   width of the term counter
// PORTS
//  clk        in   1       clock, all state on rising edge
//  reset      in   1       synchronous, active-high
//  in_valid   in   1       operand pair valid
//  in_ready   out  1       engine can accept a pair this cycle
//  in_a       in   DATA_W  multiplicand
//  in_b       in   DATA_W  multiplier
//  in_last    in   1       this pair is the final term of the vector
//  out_valid  out  1       result held in output register
//  out_ready  in   1       consumer takes result this cycle
//  out_acc    out  ACC_W   accumulated dot product
//  out_ovf    out  1       overflow occurred at least once in this vector (sticky)
//  out_cnt    out  CNT_W   terms in this vector (saturates at all-ones)
// BEHAVIOUR
//  - Reset: all stage valids, accumulator, counter, sticky ovf = 0; out_valid=0,
//    out_acc=0, out_ovf=0, out_cnt=0. Reset mid-vector discards partial sum/in-flight.
//  - Pipeline S1 (operand regs) -> S2 (product reg, 2*DATA_W) -> S3 (accumulate).
//    Global advance en = !(out_valid && !out_ready); in_ready = en; no comb path
//    from in_valid to in_ready. Accept = in_valid && in_ready.
//  - Latency: last term accepted at edge T -> out_valid high after edge T+3.
//    Full throughput: one pair/cycle, back-to-back vectors with no bubble.
//  - S3: sum = acc + sext/zext(product) at ACC_W+1 bits. Overflow = carry out
//    (unsigned) or sign mismatch (signed). SATURATE=1: clamp to 2^ACC_W-1 /
//    signed max or min by direction; SATURATE=0: wrap. ovf sticky ORs in.
//  - Non-last term: acc<=sum, cnt<=cnt+1 (hold at max). Last term: output regs load
//    {sum, ovf|this_ovf, cnt+1}, out_valid<=1; acc, cnt, ovf reset to 0 same edge.
//  - Output hold: while out_valid && !out_ready, out_* stable and whole pipe stalls.
//    out_valid && out_ready with a new last in S3 same cycle: reload, out_valid stays 1.
//    out_ready with no new result: out_valid<=0, out_acc etc. hold last value.
//  - Bubbles (invalid stage) do not change acc/cnt. Single-term vector (in_last on
//    first pair) gives out_acc = a*b, out_cnt = 1.
//  - Saturated acc continues accumulating from clamped value (may recover).
// TESTING
//  1 Single term a=3,b=5,last=1 -> out_valid 3 cycles later, acc=15, cnt=1, ovf=0.
//  2 Vector (1,2),(3,4),(5,6),(7,8) last on 4th, out_ready=1 -> acc=100, cnt=4;
//    second vector follows next cycle with no bubble, result independent of first.
//  3 Hold out_ready=0 for 5 cycles with result pending -> in_ready=0, out_acc stable,
//    no terms lost; release -> following vector results correct and in order.
//  4 DATA_W=32,ACC_W=64,SATURATE=1: 2 terms of 0xFFFFFFFF^2 -> acc=0xFFFF..FF,
//    ovf=1; SATURATE=0 same stimulus -> wrapped sum, ovf=1.
//  5 SIGNED=1: (-3)*4 + 2*5 last -> acc=-2 (all-ones ...FE), ovf=0.
//  6 Assert reset after 2 of 4 terms -> outputs 0; new 1-term vector 2*2 -> acc=4.

Source files
------------

// File: rtl/mac_stream.sv
// Streaming multiply-accumulate engine: operand regs -> product reg -> accumulate -> output reg.
// One operand pair per cycle; a term tagged in_last closes the vector and emits its result.
module mac_stream #(
    parameter int DATA_W   = 32,
    parameter int ACC_W    = 72,
    parameter int SIGNED   = 0,
    parameter int SATURATE = 0,
    parameter int CNT_W    = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_a,
    input  logic [DATA_W-1:0] in_b,
    input  logic              in_last,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ACC_W-1:0]  out_acc,
    output logic              out_ovf,
    output logic [CNT_W-1:0]  out_cnt
);

    localparam int PROD_W = 2 * DATA_W;
    localparam bit SGN    = (SIGNED != 0);
    localparam bit SAT    = (SATURATE != 0);

    logic                en;

    logic                s1_valid;
    logic                s1_last;
    logic [DATA_W-1:0]   s1_a;
    logic [DATA_W-1:0]   s1_b;

    logic                s2_valid;
    logic                s2_last;
    logic [PROD_W-1:0]   s2_prod;

    logic [ACC_W-1:0]    acc;
    logic                ovf;
    logic [CNT_W-1:0]    cnt;

    logic                s3_valid;
    logic [ACC_W-1:0]    s3_acc;
    logic                s3_ovf;
    logic [CNT_W-1:0]    s3_cnt;

    logic [PROD_W-1:0]   a_ext;
    logic [PROD_W-1:0]   b_ext;
    logic [PROD_W-1:0]   prod;
    logic [ACC_W:0]      acc_x;
    logic [ACC_W:0]      prod_x;
    logic [ACC_W:0]      sum_x;
    logic                step_ovf;
    logic [ACC_W-1:0]    acc_nxt;
    logic [CNT_W-1:0]    cnt_nxt;

    // The whole pipe moves together; only a refused result can stall it.
    assign en       = !(out_valid && !out_ready);
    assign in_ready = en;

    // Operands widened to the full product width so one multiplier serves both modes.
    assign a_ext = {{DATA_W{SGN & s1_a[DATA_W-1]}}, s1_a};
    assign b_ext = {{DATA_W{SGN & s1_b[DATA_W-1]}}, s1_b};
    assign prod  = a_ext * b_ext;

    // One guard bit above the accumulator exposes carry-out or the true sign.
    assign acc_x    = {SGN & acc[ACC_W-1], acc};
    assign prod_x   = {{(ACC_W+1-PROD_W){SGN & s2_prod[PROD_W-1]}}, s2_prod};
    assign sum_x    = acc_x + prod_x;
    assign step_ovf = SGN ? (sum_x[ACC_W] ^ sum_x[ACC_W-1]) : sum_x[ACC_W];
    assign cnt_nxt  = (&cnt) ? cnt : cnt + CNT_W'(1);

    always_comb begin
        acc_nxt = sum_x[ACC_W-1:0];
        if (SAT && step_ovf) begin
            if (!SGN) begin
                acc_nxt = '1;
            end else if (sum_x[ACC_W]) begin
                acc_nxt = {1'b1, {(ACC_W-1){1'b0}}};
            end else begin
                acc_nxt = {1'b0, {(ACC_W-1){1'b1}}};
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            s1_valid <= 1'b0;
            s1_last  <= 1'b0;
            s1_a     <= '0;
            s1_b     <= '0;
            s2_valid <= 1'b0;
            s2_last  <= 1'b0;
            s2_prod  <= '0;
        end else if (en) begin
            s1_valid <= in_valid;
            s1_last  <= in_last;
            s1_a     <= in_a;
            s1_b     <= in_b;
            s2_valid <= s1_valid;
            s2_last  <= s1_last;
            s2_prod  <= prod;
        end
    end

    // Closing a vector clears the running state on the same edge so the next
    // vector can start accumulating without a bubble.
    always_ff @(posedge clk) begin
        if (reset) begin
            acc      <= '0;
            ovf      <= 1'b0;
            cnt      <= '0;
            s3_valid <= 1'b0;
            s3_acc   <= '0;
            s3_ovf   <= 1'b0;
            s3_cnt   <= '0;
        end else if (en) begin
            s3_valid <= s2_valid && s2_last;
            if (s2_valid) begin
                if (s2_last) begin
                    s3_acc <= acc_nxt;
                    s3_ovf <= ovf | step_ovf;
                    s3_cnt <= cnt_nxt;
                    acc    <= '0;
                    ovf    <= 1'b0;
                    cnt    <= '0;
                end else begin
                    acc    <= acc_nxt;
                    ovf    <= ovf | step_ovf;
                    cnt    <= cnt_nxt;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            out_valid <= 1'b0;
            out_acc   <= '0;
            out_ovf   <= 1'b0;
            out_cnt   <= '0;
        end else if (en) begin
            out_valid <= s3_valid;
            if (s3_valid) begin
                out_acc <= s3_acc;
                out_ovf <= s3_ovf;
                out_cnt <= s3_cnt;
            end
        end
    end

endmodule
